// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - pipeline stall/flush sequencer with saturating perf counters
//
// Purpose: decides, every cycle, whether the front end of the 5-stage core advances,
// stalls for a load-use hazard, flushes after an EX redirect, or freezes for data memory.
// A redirect arriving while memory is busy is parked and applied when busy drops.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   id_instr             instruction word in IF/ID
//   ex_mem_read, ex_rd   load flag and destination register of the EX instruction
//   ex_redirect          single-cycle taken branch/jump pulse from EX
//   dmem_busy            data memory not ready, freeze everything
//   pc_en, ifid_en       PC and IF/ID write enables
//   id_flush             force the ID instruction to a NOP
//   idex_bubble          load a NOP into ID/EX
//   state                0=RUN, 1=FLUSH, 2=MEMW
//   stall_cnt, flush_cnt saturating counts of pc_en=0 and id_flush=1 cycles
module hazard_flush_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             id_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_MEMW  = 2'd2;

    // Remaining-cycle count loaded when a flush window opens; the redirect cycle itself
    // is the first flush cycle, so the window needs FLUSH_CYCLES-1 more.
    localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI  = (FLUSH_CYCLES > 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic use_rs1, use_rs2, load_use, redirect;
    logic pc_en_c, ifid_en_c, id_flush_c, idex_bubble_c;

    // Only the opcode and the two source fields matter for hazard detection.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:7]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_instr[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((use_rs1 && (id_instr[19:15] == ex_rd)) ||
                       (use_rs2 && (id_instr[24:20] == ex_rd)));

    assign redirect = ex_redirect | pend_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        id_flush_c    = 1'b0;
        idex_bubble_c = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                if (dmem_busy) begin
                    // Freeze mid-flush: keep the NOP in ID, hold the window, park any redirect.
                    pc_en_c    = 1'b0;
                    ifid_en_c  = 1'b0;
                    id_flush_c = 1'b1;
                    pend_d     = redirect;
                end else begin
                    id_flush_c    = 1'b1;
                    idex_bubble_c = 1'b1;
                    if (redirect) begin
                        cnt_d  = RELOAD;
                        pend_d = 1'b0;
                    end else if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                // RUN, and MEMW once busy has dropped, share the same decision.
                if (dmem_busy) begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    pend_d    = redirect;
                    state_d   = ST_MEMW;
                end else if (redirect) begin
                    id_flush_c    = 1'b1;
                    idex_bubble_c = 1'b1;
                    pend_d        = 1'b0;
                    if (MULTI) begin
                        state_d = ST_FLUSH;
                        cnt_d   = RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (load_use) begin
                    pc_en_c       = 1'b0;
                    ifid_en_c     = 1'b0;
                    idex_bubble_c = 1'b1;
                    state_d       = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
        if (id_flush_c && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Reset overrides the outputs combinationally so the pipeline is quiesced at once.
    assign pc_en       = rst_n & pc_en_c;
    assign ifid_en     = rst_n & ifid_en_c;
    assign id_flush    = ~rst_n | id_flush_c;
    assign idex_bubble = ~rst_n | idex_bubble_c;
    assign state       = state_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb/tb_hazard_flush_ctrl.sv - self-checking bench for hazard_flush_ctrl
module tb_hazard_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        dmem_busy;

    logic        a_pc, a_if, a_fl, a_bu;
    logic [1:0]  a_st;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_if, b_fl, b_bu;
    logic [1:0]  b_st;
    logic [3:0]  b_stall, b_flush;

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .pc_en(a_pc), .ifid_en(a_if), .id_flush(a_fl), .idex_bubble(a_bu),
        .state(a_st), .stall_cnt(a_stall), .flush_cnt(a_flush));

    hazard_flush_ctrl #(.FLUSH_CYCLES(15), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .pc_en(b_pc), .ifid_en(b_if), .id_flush(b_fl), .idex_bubble(b_bu),
        .state(b_st), .stall_cnt(b_stall), .flush_cnt(b_flush));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: remaining flush cycles as an integer, a parked-redirect flag,
    // a memory-wait flag, and plain saturating integer counters.
    int FCV[2]  = '{3, 15};
    int MAXC[2] = '{65535, 15};
    int m_rem[2], m_stall[2], m_flush[2];
    bit m_pend[2], m_memw[2];
    int n_rem[2], n_stall[2], n_flush[2];
    bit n_pend[2], n_memw[2];
    bit e_pc[2], e_if[2], e_fl[2], e_bu[2];
    int e_st[2];

    function automatic bit model_lu();
        logic [6:0] op;
        bit r1, r2;
        op = id_instr[6:0];
        r1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return ex_mem_read && (ex_rd != 0) &&
               ((r1 && id_instr[19:15] == ex_rd) || (r2 && id_instr[24:20] == ex_rd));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_pend[i] = 0; m_memw[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
    endtask

    task automatic set_out(input int i, input bit p, input bit f, input bit fl, input bit b);
        e_pc[i] = p; e_if[i] = f; e_fl[i] = fl; e_bu[i] = b;
    endtask

    task automatic model_calc();
        bit redir;
        for (int i = 0; i < 2; i++) begin
            n_rem[i] = m_rem[i]; n_pend[i] = m_pend[i]; n_memw[i] = m_memw[i];
            redir = ex_redirect | m_pend[i];
            e_st[i] = (m_rem[i] > 0) ? 1 : (m_memw[i] ? 2 : 0);
            if (!rst_n) begin
                set_out(i, 0, 0, 1, 1);
                e_st[i] = 0;
            end else if (m_rem[i] > 0) begin
                n_memw[i] = 0;
                if (dmem_busy) begin
                    set_out(i, 0, 0, 1, 0);
                    n_pend[i] = redir;
                end else begin
                    set_out(i, 1, 1, 1, 1);
                    if (redir) begin n_rem[i] = FCV[i] - 1; n_pend[i] = 0; end
                    else n_rem[i] = m_rem[i] - 1;
                end
            end else if (dmem_busy) begin
                set_out(i, 0, 0, 0, 0);
                n_pend[i] = redir;
                n_memw[i] = 1;
            end else begin
                n_memw[i] = 0;
                if (redir) begin
                    set_out(i, 1, 1, 1, 1);
                    n_rem[i] = FCV[i] - 1;
                    n_pend[i] = 0;
                end else if (model_lu()) set_out(i, 0, 0, 0, 1);
                else set_out(i, 1, 1, 0, 0);
            end
            n_stall[i] = (m_stall[i] + (e_pc[i] ? 0 : 1) > MAXC[i]) ? MAXC[i] : m_stall[i] + (e_pc[i] ? 0 : 1);
            n_flush[i] = (m_flush[i] + (e_fl[i] ? 1 : 0) > MAXC[i]) ? MAXC[i] : m_flush[i] + (e_fl[i] ? 1 : 0);
        end
    endtask

    task automatic model_cmp();
        chk("m_a_pc_en", a_pc, e_pc[0]);    chk("m_a_ifid_en", a_if, e_if[0]);
        chk("m_a_id_flush", a_fl, e_fl[0]); chk("m_a_bubble", a_bu, e_bu[0]);
        chk("m_a_state", a_st, e_st[0]);    chk("m_a_stall", a_stall, m_stall[0]);
        chk("m_a_flushc", a_flush, m_flush[0]);
        chk("m_b_pc_en", b_pc, e_pc[1]);    chk("m_b_ifid_en", b_if, e_if[1]);
        chk("m_b_id_flush", b_fl, e_fl[1]); chk("m_b_bubble", b_bu, e_bu[1]);
        chk("m_b_state", b_st, e_st[1]);    chk("m_b_stall", b_stall, m_stall[1]);
        chk("m_b_flushc", b_flush, m_flush[1]);
    endtask

    // Called at the negedge: evaluate model on current inputs, then commit at the edge.
    task automatic adv();
        model_calc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else for (int i = 0; i < 2; i++) begin
            m_rem[i] = n_rem[i]; m_pend[i] = n_pend[i]; m_memw[i] = n_memw[i];
            m_stall[i] = n_stall[i]; m_flush[i] = n_flush[i];
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input bit mr, input logic [4:0] rd,
                         input bit redir, input bit busy);
        id_instr = ins; ex_mem_read = mr; ex_rd = rd; ex_redirect = redir; dmem_busy = busy;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive(32'h00000013, 0, 0, 0, 0);
            @(negedge clk);
            adv();
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        bit          mr;
        logic [4:0]  rd;
        bit          e_pc;
        bit          e_bu;
        string       nm;
    } vec_t;

    vec_t vt[13];
    logic [31:0] pool[8];

    initial begin
        vt[0]  = '{32'h002081B3, 0, 5'd0, 1, 0, "add_idle"};
        vt[1]  = '{32'h00128313, 1, 5'd5, 0, 1, "addi_rs1_hit"};
        vt[2]  = '{32'h00128313, 1, 5'd0, 1, 0, "addi_x0"};
        vt[3]  = '{32'h000282B7, 1, 5'd5, 1, 0, "lui_no_use"};
        vt[4]  = '{32'h0050A023, 1, 5'd5, 0, 1, "sw_rs2_hit"};
        vt[5]  = '{32'h00128313, 1, 5'd1, 1, 0, "addi_rs2_field"};
        vt[6]  = '{32'h002081B3, 1, 5'd2, 0, 1, "add_rs2_hit"};
        vt[7]  = '{32'h005000EF, 1, 5'd5, 1, 0, "jal_no_use"};
        vt[8]  = '{32'h00628063, 1, 5'd6, 0, 1, "beq_rs2_hit"};
        vt[9]  = '{32'h00038067, 1, 5'd7, 0, 1, "jalr_rs1_hit"};
        vt[10] = '{32'h0004A083, 1, 5'd1, 1, 0, "lw_rd_only"};
        vt[11] = '{32'h0004A083, 1, 5'd9, 0, 1, "lw_rs1_hit"};
        vt[12] = '{32'h002081B3, 0, 5'd2, 1, 0, "add_not_load"};
        for (int i = 0; i < 13; i++) pool[i % 8] = vt[i].instr;

        rst_n = 1'b0;
        drive(32'h00000013, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        chk("rst_pc_en", a_pc, 0);      chk("rst_ifid_en", a_if, 0);
        chk("rst_id_flush", a_fl, 1);   chk("rst_bubble", a_bu, 1);
        chk("rst_state", a_st, 0);      chk("rst_stall", a_stall, 0);
        chk("rst_flushc", a_flush, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-cycle hazard decode from RUN.
        begin
            int exp_stall = 0;
            for (int i = 0; i < 13; i++) begin
                drive(vt[i].instr, vt[i].mr, vt[i].rd, 0, 0);
                @(negedge clk);
                chk({vt[i].nm, "_pc_en"}, a_pc, vt[i].e_pc);
                chk({vt[i].nm, "_ifid_en"}, a_if, vt[i].e_pc);
                chk({vt[i].nm, "_id_flush"}, a_fl, 0);
                chk({vt[i].nm, "_bubble"}, a_bu, vt[i].e_bu);
                chk({vt[i].nm, "_state"}, a_st, 0);
                chk({vt[i].nm, "_stall_cnt"}, a_stall, exp_stall);
                if (!vt[i].e_pc) exp_stall++;
                adv();
            end
            @(negedge clk);
            chk("table_stall_final", a_stall, exp_stall);
            adv();
        end

        // Three-cycle flush window.
        drive(32'h00000013, 0, 0, 1, 0);
        @(negedge clk);
        chk("rd0_flushc", a_flush, 0); chk("rd0_state", a_st, 0);
        chk("rd0_id_flush", a_fl, 1);  chk("rd0_pc_en", a_pc, 1);
        adv();
        for (int k = 1; k <= 3; k++) begin
            drive(32'h00000013, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("rd%0d_state", k), a_st, (k == 3) ? 0 : 1);
            chk($sformatf("rd%0d_id_flush", k), a_fl, (k == 3) ? 0 : 1);
            adv();
        end
        @(negedge clk);
        chk("rd_flush_cnt", a_flush, 3);
        adv();

        // Redirect parked during a 4-cycle memory stall.
        for (int k = 0; k < 4; k++) begin
            drive(32'h00000013, 0, 0, (k == 1), 1);
            @(negedge clk);
            chk($sformatf("mw%0d_pc_en", k), a_pc, 0);
            chk($sformatf("mw%0d_state", k), a_st, (k == 0) ? 0 : 2);
            adv();
        end
        drive(32'h00000013, 0, 0, 0, 0);
        @(negedge clk);
        chk("mw_exit_id_flush", a_fl, 1); chk("mw_exit_pc_en", a_pc, 1);
        chk("mw_exit_state", a_st, 2);
        adv();
        idle_cycles(3);
        @(negedge clk);
        chk("mw_drain_state", a_st, 0);
        adv();

        // Redirect beats load-use.
        drive(32'h00128313, 1, 5'd5, 1, 0);
        @(negedge clk);
        chk("lu_rd_pc_en", a_pc, 1); chk("lu_rd_id_flush", a_fl, 1);
        adv();
        idle_cycles(3);

        // Busy beats redirect; flush applied once busy drops.
        drive(32'h00000013, 0, 0, 1, 1);
        @(negedge clk);
        chk("br_pc_en", a_pc, 0); chk("br_id_flush", a_fl, 0);
        adv();
        drive(32'h00000013, 0, 0, 0, 0);
        @(negedge clk);
        chk("br_after_id_flush", a_fl, 1); chk("br_after_pc_en", a_pc, 1);
        adv();
        idle_cycles(3);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 3) == 0) ? 32'($urandom) : pool[$urandom_range(0, 7)],
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 9)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            @(negedge clk);
            model_calc();
            model_cmp();
            adv();
        end

        // Saturation of a 4-bit flush counter, then asynchronous reset mid-flush.
        drive(32'h00000013, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        adv();
        rst_n = 1'b1;
        model_reset();
        drive(32'h00000013, 0, 0, 1, 0);
        @(negedge clk);
        adv();
        idle_cycles(10);
        drive(32'h00000013, 0, 0, 1, 0);
        @(negedge clk);
        adv();
        idle_cycles(8);
        @(negedge clk);
        chk("sat_flush_cnt", b_flush, 15);
        chk("sat_state", b_st, 1);
        rst_n = 1'b0;
        #1;
        chk("async_state", b_st, 0);       chk("async_flushc", b_flush, 0);
        chk("async_stall", b_stall, 0);    chk("async_a_flushc", a_flush, 0);
        chk("async_id_flush", b_fl, 1);    chk("async_pc_en", b_pc, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(32'h00000013, 0, 0, 0, 0);
        @(negedge clk);
        model_calc();
        model_cmp();
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
